// File: rtl/gam_node_update_seq.sv
// gam_node_update_seq
//   Sequential GAM winner-node update engine. For each element i of the
//   node vectors:
//     Ws1'[i] = Ws1[i] + (X[i]-Ws1[i]) / Ms1
//     Ws2'[i] = Ws2[i] + (X[i]-Ws2[i]) / (NBR_SCALE*Ms1)
//   and once per request Ths1' = (Ths1 + min1_ED) / 2. All divisions are
//   signed and truncate toward zero. LANES elements are updated per CALC
//   cycle. The block sits between the winner-search stage and node memory
//   write-back.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
//   where valid && ready are both 1. in_ready is 1 only while idle; the
//   request inputs are captured on the accepting edge and not looked at
//   again. out_valid is 1 only while a result is waiting; all result outputs
//   are held stable until the out_valid && out_ready edge. There is no
//   same-cycle re-accept: in_ready rises the cycle after the result leaves.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   x_in, ws1_in, ws2_in  VECTOR_LEN*DATA_W vectors, element i at [i*DATA_W +: DATA_W]
//   ms1_in                winner hit count (unsigned; 0 is treated as 1)
//   ths1_in, min1_ed      winner threshold and distance (signed)
//   out_valid / out_ready result handshake
//   ws1_out, ws2_out      updated weight vectors
//   ths1_out              updated threshold (signed)
//   div_zero              ms1_in was 0 for this result
module gam_node_update_seq #(
  parameter int VECTOR_LEN = 8,
  parameter int DATA_W     = 8,
  parameter int LANES      = 1,
  parameter int NBR_SCALE  = 100
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [VECTOR_LEN*DATA_W-1:0]   x_in,
  input  logic [VECTOR_LEN*DATA_W-1:0]   ws1_in,
  input  logic [VECTOR_LEN*DATA_W-1:0]   ws2_in,
  input  logic [31:0]                    ms1_in,
  input  logic [31:0]                    ths1_in,
  input  logic [31:0]                    min1_ed,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [VECTOR_LEN*DATA_W-1:0]   ws1_out,
  output logic [VECTOR_LEN*DATA_W-1:0]   ws2_out,
  output logic [31:0]                    ths1_out,
  output logic                           div_zero
);

  localparam int VW       = VECTOR_LEN * DATA_W;
  localparam int NGRP     = VECTOR_LEN / LANES;
  localparam int GW       = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);
  localparam logic [39:0]   NBR40    = 40'(NBR_SCALE);

  if (VECTOR_LEN % LANES != 0) begin : g_bad_lanes
    $error("gam_node_update_seq: VECTOR_LEN must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic [VW-1:0]   x_q, ws1_q, ws2_q;
  logic [39:0]     div1_q, div2_q;
  logic            dz_q;
  logic [31:0]     ths_q, med_q;
  logic [GW-1:0]   grp_q;

  // One element update. The operands are widened to 41 bits so the 40-bit
  // second-winner divisor stays positive; the quotient magnitude never
  // exceeds |X-W|, so W+q always fits back into DATA_W unsigned bits and the
  // two extra result bits must be zero.
  function automatic logic signed [DATA_W+1:0] lane_update(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] w,
    input logic [39:0]       div
  );
    logic signed [40:0] xs, ws, ds, q, s;
    xs = $signed({{(41-DATA_W){1'b0}}, x});
    ws = $signed({{(41-DATA_W){1'b0}}, w});
    ds = $signed({1'b0, div});
    q  = (xs - ws) / ds;
    s  = ws + q;
    return (DATA_W+2)'(s);
  endfunction

  logic signed [DATA_W+1:0] sum1 [LANES];
  logic signed [DATA_W+1:0] sum2 [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum1[l] = lane_update(x_q[(int'(grp_q)*LANES + l)*DATA_W +: DATA_W],
                            ws1_q[(int'(grp_q)*LANES + l)*DATA_W +: DATA_W],
                            div1_q);
      sum2[l] = lane_update(x_q[(int'(grp_q)*LANES + l)*DATA_W +: DATA_W],
                            ws2_q[(int'(grp_q)*LANES + l)*DATA_W +: DATA_W],
                            div2_q);
    end
  end

  // Threshold: 33-bit sum cannot overflow; halving brings it back into 32.
  logic signed [32:0] ths_sum;
  logic [31:0]        ths_half;
  assign ths_sum  = $signed({ths_q[31], ths_q}) + $signed({med_q[31], med_q});
  assign ths_half = 32'(ths_sum / 33'sd2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CALC;
      S_CALC:  if (grp_q == LAST_GRP) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // Datapath. Result registers only change in CALC, so they keep the last
  // result through DONE and the following IDLE period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      ws1_q    <= '0;
      ws2_q    <= '0;
      div1_q   <= '0;
      div2_q   <= '0;
      dz_q     <= 1'b0;
      ths_q    <= '0;
      med_q    <= '0;
      grp_q    <= '0;
      ws1_out  <= '0;
      ws2_out  <= '0;
      ths1_out <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q    <= x_in;
            ws1_q  <= ws1_in;
            ws2_q  <= ws2_in;
            ths_q  <= ths1_in;
            med_q  <= min1_ed;
            grp_q  <= '0;
            // A zero hit count is treated as one and flagged.
            dz_q   <= (ms1_in == 32'd0);
            div1_q <= (ms1_in == 32'd0) ? 40'd1 : {8'd0, ms1_in};
            div2_q <= (ms1_in == 32'd0) ? NBR40 : NBR40 * {8'd0, ms1_in};
          end
        end
        S_CALC: begin
          for (int l = 0; l < LANES; l++) begin
            assert (sum1[l][DATA_W+1:DATA_W] == 2'b00);
            assert (sum2[l][DATA_W+1:DATA_W] == 2'b00);
            ws1_out[(int'(grp_q)*LANES + l)*DATA_W +: DATA_W] <= sum1[l][DATA_W-1:0];
            ws2_out[(int'(grp_q)*LANES + l)*DATA_W +: DATA_W] <= sum2[l][DATA_W-1:0];
          end
          if (grp_q == '0) ths1_out <= ths_half;
          div_zero <= dz_q;
          grp_q    <= grp_q + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
